// File: rtl/pio_pkg.sv
// Shared types and widths for the PIO arbiter slice.
package pio_pkg;

    localparam int unsigned PIO_ADDR_W = 16;
    localparam int unsigned PIO_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } pio_arb_state_e;

    typedef struct packed {
        logic [PIO_ADDR_W-1:0] addr;
        logic [PIO_DATA_W-1:0] data_w;
        logic                  rw;
    } pio_cmd_t;

    // Timeout counter width; a zero timeout still needs one bit of storage.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pio_arbiter_if.sv
// Requester-side and PIO-bus-side signals of the shared PIO master port.
interface pio_arbiter_if
    import pio_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ*PIO_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*PIO_DATA_W-1:0] req_data_w;
    logic [NUM_REQ-1:0]            req_rw;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            rsp_vld;
    logic [PIO_DATA_W-1:0]         rsp_data;
    logic                          rsp_err;

    logic                          cmd_vld;
    logic [PIO_ADDR_W-1:0]         addr;
    logic [PIO_DATA_W-1:0]         data_w;
    logic                          rw;
    logic [PIO_DATA_W-1:0]         data_r;
    logic                          rd_vld;

    // Arbiter view: owns the bus command and the requester responses.
    modport master (
        input  req_vld, req_addr, req_data_w, req_rw, data_r, rd_vld,
        output req_ack, rsp_vld, rsp_data, rsp_err, cmd_vld, addr, data_w, rw
    );

    // Environment view: requesters plus the PIO slave.
    modport slave (
        output req_vld, req_addr, req_data_w, req_rw, data_r, rd_vld,
        input  req_ack, rsp_vld, rsp_data, rsp_err, cmd_vld, addr, data_w, rw
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational rotate-priority select: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid_c,
    output logic [IDX_W-1:0]   idx_c
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid_c = |req;
        idx_c   = '0;
        sum     = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum = {1'b0, ptr} + SUM_W'(off);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            if (req[sum[IDX_W-1:0]]) begin
                idx_c = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pio_arbiter.sv
// Round-robin arbiter/sequencer sharing one PIO master port between NUM_REQ requesters;
// one command outstanding, read timeout reported through rsp_err.
module pio_arbiter
    import pio_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    pio_arbiter_if.master bus
);

    localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned      CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    pio_arb_state_e        state_q,    state_d;
    logic [IDX_W-1:0]      grant_q,    grant_d;
    logic [IDX_W-1:0]      rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    pio_cmd_t              cmd_q,      cmd_d;
    logic                  cmd_vld_q,  cmd_vld_d;
    logic [NUM_REQ-1:0]    req_ack_q,  req_ack_d;
    logic [NUM_REQ-1:0]    rsp_vld_q,  rsp_vld_d;
    logic [PIO_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q,  rsp_err_d;

    logic                  pick_valid_c;
    logic [IDX_W-1:0]      pick_idx_c;
    logic                  timeout_hit_c;
    pio_cmd_t              req_cmd [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req_cmd[i] = '{
            addr:   bus.req_addr[PIO_ADDR_W*i +: PIO_ADDR_W],
            data_w: bus.req_data_w[PIO_DATA_W*i +: PIO_DATA_W],
            rw:     bus.req_rw[i]
        };
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (bus.req_vld),
        .ptr     (rr_ptr_q),
        .valid_c (pick_valid_c),
        .idx_c   (pick_idx_c)
    );

    // A zero TIMEOUT disables the limit entirely.
    assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // State and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            cmd_q      <= '0;
            cmd_vld_q  <= 1'b0;
            req_ack_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            cmd_vld_q  <= cmd_vld_d;
            req_ack_q  <= req_ack_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid_c) state_d = CMD;
            CMD:     state_d = cmd_q.rw ? RESP : WAIT_RD;
            WAIT_RD: if (bus.rd_vld || timeout_hit_c) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the output/data registers, so each output is valid in the state it belongs to.
    always_comb begin
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        cmd_vld_d  = 1'b0;
        req_ack_d  = '0;
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    grant_d               = pick_idx_c;
                    cmd_d                 = req_cmd[pick_idx_c];
                    cmd_vld_d             = 1'b1;
                    req_ack_d[pick_idx_c] = 1'b1;
                end
            end
            CMD: begin
                cnt_d = '0;
                if (cmd_q.rw) begin
                    rsp_vld_d[grant_q] = 1'b1;
                    rsp_data_d         = '0;
                    rsp_err_d          = 1'b0;
                end
            end
            WAIT_RD: begin
                if (bus.rd_vld) begin
                    rsp_vld_d[grant_q] = 1'b1;
                    rsp_data_d         = bus.data_r;
                    rsp_err_d          = 1'b0;
                end else if (timeout_hit_c) begin
                    rsp_vld_d[grant_q] = 1'b1;
                    rsp_data_d         = '0;
                    rsp_err_d          = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cmd_vld  = cmd_vld_q;
    assign bus.addr     = cmd_q.addr;
    assign bus.data_w   = cmd_q.data_w;
    assign bus.rw       = cmd_q.rw;
    assign bus.req_ack  = req_ack_q;
    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_pio_arbiter.sv
// Directed bench for pio_arbiter: writes, reads, timeout, stray rd_vld, reset abort, round robin.
module tb_pio_arbiter;
    import pio_pkg::*;

    localparam int unsigned NR = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    pio_arbiter_if #(.NUM_REQ(NR)) bus ();

    pio_arbiter #(
        .NUM_REQ (NR),
        .TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [31:0] d, input logic w);
        bus.req_addr[16*i +: 16]   = a;
        bus.req_data_w[32*i +: 32] = d;
        bus.req_rw[i]              = w;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_vld"},  64'(bus.cmd_vld),  64'd0);
        chk({tag, "_req_ack"},  64'(bus.req_ack),  64'd0);
        chk({tag, "_rsp_vld"},  64'(bus.rsp_vld),  64'd0);
        chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
        chk({tag, "_rsp_err"},  64'(bus.rsp_err),  64'd0);
        chk({tag, "_addr"},     64'(bus.addr),     64'd0);
        chk({tag, "_data_w"},   64'(bus.data_w),   64'd0);
        chk({tag, "_rw"},       64'(bus.rw),       64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.req_vld    = '0;
        bus.req_addr   = '0;
        bus.req_data_w = '0;
        bus.req_rw     = '0;
        bus.data_r     = '0;
        bus.rd_vld     = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single write from requester 2.
        set_req(2, 16'h0010, 32'hDEADBEEF, 1'b1);
        bus.req_vld = 4'b0100;
        tick();
        chk("wr_cmd_vld", 64'(bus.cmd_vld), 64'd1);
        chk("wr_req_ack", 64'(bus.req_ack), 64'h4);
        chk("wr_addr",    64'(bus.addr),    64'h0010);
        chk("wr_data_w",  64'(bus.data_w),  64'hDEADBEEF);
        chk("wr_rw",      64'(bus.rw),      64'd1);
        bus.req_vld = '0;
        tick();
        chk("wr_rsp_vld",  64'(bus.rsp_vld),  64'h4);
        chk("wr_rsp_err",  64'(bus.rsp_err),  64'd0);
        chk("wr_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("wr_cmd_off",  64'(bus.cmd_vld),  64'd0);
        tick();
        chk("wr_rsp_once", 64'(bus.rsp_vld), 64'd0);

        // Read from requester 0, data three cycles after the command.
        set_req(0, 16'h0004, 32'h0, 1'b0);
        bus.req_vld = 4'b0001;
        tick();
        chk("rd_cmd_vld", 64'(bus.cmd_vld), 64'd1);
        chk("rd_req_ack", 64'(bus.req_ack), 64'h1);
        chk("rd_addr",    64'(bus.addr),    64'h0004);
        chk("rd_rw",      64'(bus.rw),      64'd0);
        bus.req_vld = '0;
        tick();
        chk("rd_wait1", 64'(bus.rsp_vld), 64'd0);
        tick();
        chk("rd_wait2", 64'(bus.rsp_vld), 64'd0);
        tick();
        chk("rd_wait3",     64'(bus.rsp_vld), 64'd0);
        chk("rd_cmd_quiet", 64'(bus.cmd_vld), 64'd0);
        bus.data_r = 32'h12345678;
        bus.rd_vld = 1'b1;
        tick();
        bus.rd_vld = 1'b0;
        chk("rd_rsp_vld",  64'(bus.rsp_vld),  64'h1);
        chk("rd_rsp_data", 64'(bus.rsp_data), 64'h12345678);
        chk("rd_rsp_err",  64'(bus.rsp_err),  64'd0);
        tick();

        // Timed-out read from requester 1: response 9 cycles after the command.
        set_req(1, 16'h0020, 32'h0, 1'b0);
        bus.req_vld = 4'b0010;
        tick();
        chk("to_req_ack", 64'(bus.req_ack), 64'h2);
        bus.req_vld = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("to_wait", 64'(bus.rsp_vld), 64'd0);
        end
        tick();
        chk("to_rsp_vld",  64'(bus.rsp_vld),  64'h2);
        chk("to_rsp_err",  64'(bus.rsp_err),  64'd1);
        chk("to_rsp_data", 64'(bus.rsp_data), 64'd0);
        tick();

        // rd_vld on the final wait cycle beats the timeout.
        set_req(2, 16'h0030, 32'h0, 1'b0);
        bus.req_vld = 4'b0100;
        tick();
        chk("edge_req_ack", 64'(bus.req_ack), 64'h4);
        bus.req_vld = '0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("edge_wait", 64'(bus.rsp_vld), 64'd0);
        end
        tick();
        chk("edge_wait8", 64'(bus.rsp_vld), 64'd0);
        bus.data_r = 32'hA5A50001;
        bus.rd_vld = 1'b1;
        tick();
        bus.rd_vld = 1'b0;
        chk("edge_rsp_vld",  64'(bus.rsp_vld),  64'h4);
        chk("edge_rsp_err",  64'(bus.rsp_err),  64'd0);
        chk("edge_rsp_data", 64'(bus.rsp_data), 64'hA5A50001);
        tick();

        // Stray rd_vld while idle, then during the CMD cycle of a read from requester 3.
        bus.data_r = 32'hFFFFFFFF;
        bus.rd_vld = 1'b1;
        tick();
        chk("idle_stray_rsp", 64'(bus.rsp_vld), 64'd0);
        chk("idle_stray_cmd", 64'(bus.cmd_vld), 64'd0);
        tick();
        chk("idle_stray_rsp2", 64'(bus.rsp_vld),  64'd0);
        chk("idle_hold_data",  64'(bus.rsp_data), 64'hA5A50001);
        bus.rd_vld = 1'b0;
        set_req(3, 16'h0040, 32'h0, 1'b0);
        bus.req_vld = 4'b1000;
        tick();
        chk("stray_req_ack", 64'(bus.req_ack), 64'h8);
        bus.req_vld = '0;
        bus.rd_vld  = 1'b1;
        tick();
        bus.rd_vld = 1'b0;
        chk("stray_cmd_ignored", 64'(bus.rsp_vld), 64'd0);
        tick();
        chk("stray_wait", 64'(bus.rsp_vld), 64'd0);
        bus.data_r = 32'h0BADF00D;
        bus.rd_vld = 1'b1;
        tick();
        bus.rd_vld = 1'b0;
        chk("stray_rsp_vld",  64'(bus.rsp_vld),  64'h8);
        chk("stray_rsp_data", 64'(bus.rsp_data), 64'h0BADF00D);
        tick();

        // Move the pointer off zero, then abort a read from requester 2 with reset.
        set_req(0, 16'h0050, 32'h5555AAAA, 1'b1);
        bus.req_vld = 4'b0001;
        tick();
        chk("pre_req_ack", 64'(bus.req_ack), 64'h1);
        bus.req_vld = '0;
        tick();
        chk("pre_rsp_vld", 64'(bus.rsp_vld), 64'h1);
        tick();
        set_req(2, 16'h0060, 32'h0, 1'b0);
        bus.req_vld = 4'b0100;
        tick();
        chk("abort_req_ack", 64'(bus.req_ack), 64'h4);
        bus.req_vld = '0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        reset      = 1'b0;
        bus.data_r = 32'h77777777;
        bus.rd_vld = 1'b1;
        tick();
        bus.rd_vld = 1'b0;
        chk("post_rst_rsp", 64'(bus.rsp_vld), 64'd0);
        chk("post_rst_cmd", 64'(bus.cmd_vld), 64'd0);
        tick();
        chk("post_rst_rsp2", 64'(bus.rsp_vld), 64'd0);

        // All four requesters write continuously: grants 0,1,2,3,0,1, one command per 3 cycles.
        for (int i = 0; i < 4; i++) begin
            set_req(i, 16'h0100 + 16'(i), 32'(i), 1'b1);
        end
        bus.req_vld = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("rr_cmd_vld", 64'(bus.cmd_vld), 64'd1);
            chk("rr_req_ack", 64'(bus.req_ack), 64'd1 << (j % 4));
            chk("rr_addr",    64'(bus.addr),    64'h0100 + 64'(j % 4));
            tick();
            chk("rr_resp_cmd", 64'(bus.cmd_vld), 64'd0);
            chk("rr_rsp_vld",  64'(bus.rsp_vld), 64'd1 << (j % 4));
            tick();
            chk("rr_idle_cmd", 64'(bus.cmd_vld), 64'd0);
            chk("rr_idle_rsp", 64'(bus.rsp_vld), 64'd0);
        end
        bus.req_vld = '0;
        tick();
        chk("final_cmd", 64'(bus.cmd_vld), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pio_arbiter.md
Name: pio_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one PIO master port between NUM_REQ requesters (testbench agents, BFM sequencers, CSR bridges).
- Issues one command at a time on the PIO bus (cmd_vld/addr/data_w/rw).
- Waits for read data (rd_vld/data_r) or times out, then returns a one-cycle response to the granted requester.
- Sits directly upstream of the pio_if slave side or its wrapper.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, cycles to wait for rd_vld after a read command. 0 means wait forever.
- CNT_W, $clog2(TIMEOUT+1) (min 1), width of the timeout counter. Derived; not overridden.

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_vld  input  NUM_REQ  bit i: requester i has a pending command.
- req_addr  input  NUM_REQ*16  requester i address, slice [16*i +: 16].
- req_data_w  input  NUM_REQ*32  requester i write data, slice [32*i +: 32].
- req_rw  input  NUM_REQ  requester i direction: 0 = read, 1 = write.
- req_ack  output  NUM_REQ  one-hot pulse: requester i's command is on the bus this cycle.
- rsp_vld  output  NUM_REQ  one-hot pulse: requester i's transaction is complete.
- rsp_data  output  32  read data, valid with rsp_vld. 0 for writes and on timeout.
- rsp_err  output  1  valid with rsp_vld: 1 means read timed out.
- cmd_vld  output  1  PIO command valid.
- addr  output  16  PIO address.
- data_w  output  32  PIO write data.
- rw  output  1  PIO direction.
- data_r  input  32  PIO read data.
- rd_vld  input  1  PIO read data valid.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, state = IDLE, rr_ptr = 0, timeout counter = 0, grant index = 0. Reset asserted mid-transaction aborts it with no rsp_vld and no further bus activity.
- FSM states: IDLE, CMD, WAIT_RD, RESP.
- IDLE:
  - If any req_vld bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Latch that requester's index, addr, data_w and rw into the bus registers; go to CMD.
  - Otherwise stay in IDLE.
- CMD (exactly one cycle):
  - cmd_vld = 1 and req_ack[g] = 1; the bus fields hold the latched values.
  - Next state is RESP if rw = 1, else WAIT_RD.
  - Counter clears to 0.
- WAIT_RD:
  - cmd_vld = 0. addr, data_w and rw hold their values; don't-care to the slave.
  - If rd_vld = 1: capture data_r into rsp_data, rsp_err = 0, go to RESP.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: rsp_data = 0, rsp_err = 1, go to RESP.
  - Else increment the counter.
  - rd_vld wins over timeout when both occur in the same cycle.
- RESP (one cycle):
  - rsp_vld[g] = 1.
  - rr_ptr = (g+1) mod NUM_REQ.
  - Go to IDLE.
- Latency:
  - req_vld sampled at edge k gives cmd_vld/req_ack high in cycle k+1.
  - Write: rsp_vld in cycle k+2.
  - Read: rsp_vld one cycle after the cycle in which rd_vld is sampled.
  - Back-to-back transactions are spaced by at least 3 cycles (IDLE, CMD, RESP).
- Requester handshake:
  - The requester holds req_addr, req_data_w and req_rw stable and req_vld high until req_ack.
  - It may deassert req_vld the cycle after req_ack.
  - It must not reassert for a new command before its rsp_vld.
  - Any req_vld bit dropped before grant is simply not selected; it is not an error.
- rd_vld outside WAIT_RD (including the CMD cycle) is ignored.
- Only one transaction is ever outstanding.
- rsp_data and rsp_err hold their values until the next RESP; they are only meaningful with rsp_vld.
- Fairness: with all requesters continuously active, grants rotate 0,1,...,NUM_REQ-1,0,...
- Lowest-index priority applies only relative to rr_ptr.

Decomposition:
- Package pio_pkg:
  - PIO_ADDR_W = 16, PIO_DATA_W = 32.
  - Enum pio_arb_state_e {IDLE, CMD, WAIT_RD, RESP}.
  - Typedef pio_cmd_t {addr, data_w, rw}.
- Sub-module rr_picker (NUM_REQ): combinational rotate-priority select. Inputs: req vector and rr_ptr. Outputs: valid and index. Reusable by other shared-resource arbiters.

Test Plan:
- Single write: req 2 with addr 16'h0010, data 32'hDEADBEEF, rw 1 at cycle 0.
  - cmd_vld and req_ack[2] in cycle 1 with addr 0010 and data DEADBEEF.
  - rsp_vld[2] in cycle 2 with rsp_err 0.
- Read: req 0 with addr 16'h0004, rw 0; slave drives rd_vld with data_r 32'h12345678 three cycles after cmd.
  - rsp_vld[0] one cycle later with rsp_data 12345678 and rsp_err 0.
- Round robin: all 4 requesters write continuously.
  - Grant order 0,1,2,3,0,1.
  - No requester granted twice before all others.
  - Exactly one cmd_vld per 3 cycles.
- Timeout: TIMEOUT = 8, read with no rd_vld.
  - rsp_vld with rsp_err 1 and rsp_data 0 exactly 9 cycles after the cmd cycle.
  - Same case with rd_vld on the final wait cycle gives rsp_err 0.
- Stray and late rd_vld:
  - rd_vld pulsed in the CMD cycle and in IDLE is ignored: no rsp_vld, state unaffected.
- Reset mid-read: assert reset during WAIT_RD.
  - All outputs are 0 immediately (asynchronous).
  - After release, the next grant goes to requester 0 and no stale rsp_vld appears.
